rgb_window3x3: RTL and testbench
================================

# rgb_window3x3

Streaming 3x3 neighbourhood generator between the pixel source (`image_loader` / camera path) and the spatial filter stage. It accepts one valid-qualified RGB pixel per beat in raster order. It converts each pixel to 8-bit luma, buffers two image lines, and emits one zero-padded 3x3 luma window per pixel. Each window comes with the centre pixel's original RGB and its row/col. After the last input pixel of a frame it self-flushes, so exactly WIDTH*HEIGHT windows are produced per frame.

## Interface
- WIDTH, 640, pixels per line (>= 3)
- HEIGHT, 480, lines per frame (>= 3)
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- VGA_R, VGA_G, VGA_B  in  8 each  input pixel, raster order
- valid  in  1  input beat qualifier
- win  out  72  luma taps, tap i at win[8i+7:8i], i = 3*dy+dx, dy/dx 0..2, tap 0 = top-left, tap 4 = centre
- oVGA_R, oVGA_G, oVGA_B  out  8 each  centre pixel RGB, unmodified
- row, col  out  13 each  centre pixel coordinates
- o_valid  out  1  output beat qualifier
- frame_done  out  1  one-cycle pulse on the last window of a frame
- overrun  out  1  sticky error flag

## Operation
- Luma: Y = (77R + 150G + 29B) >> 8, computed in a 16-bit sum. Range 0..255; R=G=B=v gives Y=v.
- Line storage: two WIDTH-deep line buffers hold RGB for the previous two lines. Plus 3-column shift registers per line.
- Beat index k counts beats within a frame. An accepted input or a flush beat advances k. A beat at index k produces the window centred on pixel k-(WIDTH+1), if k >= WIDTH+1.
- Zero padding: force a tap to 0 if its neighbour lies outside the frame (row<0, row>HEIGHT-1, col<0, col>WIDTH-1). Decide this from the centre coordinates, never from buffer contents.
- States:
  - FILL: k in 0..WIDTH. Accept inputs, no output. Go to RUN after beat k=WIDTH.
  - RUN: each input beat yields one window. After beat k=WIDTH*HEIGHT-1, go to FLUSH.
  - FLUSH: internally generate one beat per clock for WIDTH+1 cycles. Input data is treated as don't-care. Then go to FILL with k=0.
- valid asserted during FLUSH: drop the beat and set overrun; overrun clears only on reset.
- Input counters wrap at end of frame: col at WIDTH-1 → 0, row at HEIGHT-1 → 0.

## Timing
- Reset (reset_n low at a clock edge) puts the block in this state at the next edge:
  - win=0, oVGA_*=0, row=0, col=0, o_valid=0, frame_done=0, overrun=0
  - state FILL, k=0
  - Line-buffer RAM is not cleared; padding masks stale data.
- Reset mid-frame discards all partial windows. The next accepted pixel is treated as (0,0).
- All outputs are registered. o_valid rises on the clock after the beat that completes the window.
- First o_valid of a frame: the cycle after input pixel (1,1) is accepted. Latency is WIDTH+1 beats plus 1 clock.
- In RUN, input gaps (valid low) stall everything and hold the outputs. o_valid is high only in cycles following a beat.
- FLUSH always runs at one beat per clock, independent of valid.
- frame_done is asserted in the same cycle as o_valid for centre (HEIGHT-1, WIDTH-1).
- A new frame's pixel may be accepted on the first cycle after FLUSH ends.

## Test plan
All scenarios use WIDTH=4, HEIGHT=3. Input R=G=B=k for beat k = 0..11, valid continuous.
- Window content:
  - Centre (0,0): win taps = 0,0,0,0,0,1,0,4,5.
  - Centre (1,1): taps = 0,1,2,4,5,6,8,9,10.
  - Centre (2,3): taps = 6,7,0,10,11,0,0,0,0.
- Count/latency:
  - o_valid first high at the clock after beat k=5.
  - Exactly 12 o_valid beats per frame, with row/col sequencing (0,0)..(2,3).
  - frame_done is a single pulse with (2,3).
- Luma: a pixel of R=255,G=0,B=0 gives centre Y=76. R=G=B=255 gives Y=255.
- Stall: insert valid=0 gaps of 1–3 cycles during RUN. The window sequence must be identical to the continuous run; outputs hold during gaps.
- Overrun: assert valid on the 2nd FLUSH cycle. overrun becomes 1 and stays 1; the 12 windows are unchanged. The next frame starts normally from (0,0).
- Reset: pulse reset_n low after beat k=7. All outputs read 0 the cycle after. A fresh 12-pixel frame then reproduces the scenario-1 windows exactly.

Source files
------------

// File: rtl/rgb_window3x3.sv
// rgb_window3x3: raster RGB stream to zero-padded 3x3 luma windows with centre RGB and coordinates.
// Self-flushes WIDTH+1 beats after the last pixel so every pixel of a frame gets a window.
module rgb_window3x3 #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B,
    input  logic        valid,
    output logic [71:0] win,
    output logic [7:0]  oVGA_R,
    output logic [7:0]  oVGA_G,
    output logic [7:0]  oVGA_B,
    output logic [12:0] row,
    output logic [12:0] col,
    output logic        o_valid,
    output logic        frame_done,
    output logic        overrun
);
    localparam int KW = $clog2(WIDTH * HEIGHT + WIDTH + 1);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t          state, state_n;
    logic [KW-1:0]   k;
    logic [CW-1:0]   in_col;
    logic [12:0]     c_row, c_col;
    logic [23:0]     lb0 [WIDTH];
    logic [23:0]     lb1 [WIDTH];
    logic [1:0][7:0] sr0, sr1, sr2;
    logic [23:0]     rgb_c, pix, top, mid;
    logic [7:0]      ny0, ny1, ny2;
    logic [71:0]     taps;
    logic            beat, out_beat, wrap, t_ok, b_ok, l_ok, r_ok;

    function automatic logic [7:0] luma(input logic [23:0] p);
        return 8'((16'd77 * 16'(p[23:16]) + 16'd150 * 16'(p[15:8]) + 16'd29 * 16'(p[7:0])) >> 8);
    endfunction

    always_comb begin
        pix      = state == FLUSH ? 24'd0 : {VGA_R, VGA_G, VGA_B};
        top      = lb0[in_col];
        mid      = lb1[in_col];
        ny0      = luma(top);
        ny1      = luma(mid);
        ny2      = luma(pix);
        beat     = state == FLUSH || valid;
        out_beat = beat && state != FILL;
        state_n  = !beat ? state :
                   state == FILL ? (k == KW'(WIDTH) ? RUN : FILL) :
                   state == RUN  ? (k == KW'(WIDTH * HEIGHT - 1) ? FLUSH : RUN) :
                   (k == KW'(WIDTH * HEIGHT + WIDTH) ? FILL : FLUSH);
        wrap     = state == FLUSH && state_n == FILL;
        // Padding depends only on where the centre sits, so stale RAM never leaks in.
        t_ok     = c_row != 13'd0;
        b_ok     = c_row != 13'(HEIGHT - 1);
        l_ok     = c_col != 13'd0;
        r_ok     = c_col != 13'(WIDTH - 1);
        taps     = {b_ok && r_ok ? ny2 : 8'd0, b_ok ? sr2[0] : 8'd0, b_ok && l_ok ? sr2[1] : 8'd0,
                    r_ok ? ny1 : 8'd0, sr1[0], l_ok ? sr1[1] : 8'd0,
                    t_ok && r_ok ? ny0 : 8'd0, t_ok ? sr0[0] : 8'd0, t_ok && l_ok ? sr0[1] : 8'd0};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= FILL;
        else          state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset_n && beat) begin
            lb0[in_col] <= mid;
            lb1[in_col] <= pix;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            k          <= '0;
            in_col     <= '0;
            c_row      <= '0;
            c_col      <= '0;
            sr0        <= '0;
            sr1        <= '0;
            sr2        <= '0;
            rgb_c      <= '0;
            win        <= '0;
            {oVGA_R, oVGA_G, oVGA_B} <= '0;
            row        <= '0;
            col        <= '0;
            o_valid    <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            o_valid    <= out_beat;
            frame_done <= out_beat && !b_ok && !r_ok;
            if (state == FLUSH && valid) overrun <= 1'b1;
            if (beat) begin
                k      <= wrap ? '0 : k + 1'b1;
                in_col <= wrap || in_col == CW'(WIDTH - 1) ? '0 : in_col + 1'b1;
                sr0    <= {sr0[0], ny0};
                sr1    <= {sr1[0], ny1};
                sr2    <= {sr2[0], ny2};
                rgb_c  <= mid;
            end
            if (out_beat) begin
                win   <= taps;
                {oVGA_R, oVGA_G, oVGA_B} <= rgb_c;
                row   <= c_row;
                col   <= c_col;
                c_col <= r_ok ? c_col + 13'd1 : 13'd0;
                c_row <= r_ok ? c_row : b_ok ? c_row + 13'd1 : 13'd0;
            end
        end
    end
endmodule

// File: tb/tb_rgb_window3x3.sv
// tb_rgb_window3x3: randomized frames against a direct neighbourhood model of a 4x3 image.
module tb_rgb_window3x3;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    typedef struct {
        logic [71:0] w;
        logic [23:0] rgb;
        logic [12:0] r;
        logic [12:0] c;
        logic        fd;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  VGA_R = '0, VGA_G = '0, VGA_B = '0;
    logic        valid = 1'b0;
    logic [71:0] win;
    logic [7:0]  oVGA_R, oVGA_G, oVGA_B;
    logic [12:0] row, col;
    logic        o_valid, frame_done, overrun;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] fr [N];
    obs_t        q[$];

    rgb_window3x3 #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .reset_n(reset_n), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .valid(valid), .win(win), .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
        .row(row), .col(col), .o_valid(o_valid), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (o_valid) q.push_back('{win, {oVGA_R, oVGA_G, oVGA_B}, row, col, frame_done});

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] y_of(input logic [23:0] p);
        return 8'((77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256);
    endfunction

    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] e = '0;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++) begin
                int rr = r + dy - 1;
                int cc = c + dx - 1;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                    e[8 * (3 * dy + dx) +: 8] = y_of(fr[rr * W + cc]);
            end
        return e;
    endfunction

    task automatic send(input int n, input int gap_max, input bit lat_chk, input bit ovr);
        for (int b = 0; b < n; b++) begin
            if (gap_max > 0 && b > W + 1) begin
                int g = $urandom_range(0, gap_max);
                for (int i = 0; i < g; i++) begin
                    valid = 1'b0;
                    @(negedge clk);
                    check("gap_ovalid", 72'(o_valid), 72'(0));
                    check("gap_hold", win, q[$].w);
                end
            end
            {VGA_R, VGA_G, VGA_B} = fr[b];
            valid = 1'b1;
            @(negedge clk);
            if (lat_chk) check("latency", 72'(o_valid), 72'(b >= W + 1));
        end
        valid = 1'b0;
        if (n == N) begin
            {VGA_R, VGA_G, VGA_B} = 24'hA5A5A5;
            @(negedge clk);
            valid = ovr;
            @(negedge clk);
            valid = 1'b0;
            repeat (W + 1) @(negedge clk);
        end
    endtask

    task automatic compare_frame();
        int t = 0;
        while (q.size() < N && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("win_count", 72'(q.size()), 72'(N));
        for (int i = 0; i < q.size() && i < N; i++) begin
            check($sformatf("win[%0d]", i), q[i].w, exp_win(i / W, i % W));
            check($sformatf("rgb[%0d]", i), 72'(q[i].rgb), 72'(fr[i]));
            check($sformatf("row[%0d]", i), 72'(q[i].r), 72'(i / W));
            check($sformatf("col[%0d]", i), 72'(q[i].c), 72'(i % W));
            check($sformatf("fdone[%0d]", i), 72'(q[i].fd), 72'(i == N - 1));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_win"}, win, '0);
        check({tag, "_rgb"}, 72'({oVGA_R, oVGA_G, oVGA_B}), '0);
        check({tag, "_rowcol"}, 72'({row, col}), '0);
        check({tag, "_flags"}, 72'({o_valid, frame_done, overrun}), '0);
    endtask

    task automatic ramp();
        for (int i = 0; i < N; i++) fr[i] = {3{8'(i)}};
    endtask

    task automatic rnd();
        for (int i = 0; i < N; i++) fr[i] = 24'($urandom);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;

        ramp();
        q.delete();
        send(N, 0, 1'b1, 1'b0);
        compare_frame();
        if (q.size() == N) begin
            check("tap_c00", q[0].w, 72'h050400010000000000);
            check("tap_c11", q[5].w, 72'h0a0908060504020100);
            check("tap_c23", q[11].w, 72'h000000000b0a000706);
        end

        rnd();
        fr[5] = 24'hFF0000;
        fr[6] = 24'hFFFFFF;
        q.delete();
        send(N, 0, 1'b0, 1'b0);
        compare_frame();
        if (q.size() == N) begin
            check("luma_red", 72'(q[5].w[39:32]), 72'd76);
            check("luma_white", 72'(q[6].w[39:32]), 72'd255);
        end

        ramp();
        q.delete();
        send(N, 3, 1'b0, 1'b0);
        compare_frame();
        for (int f = 0; f < 3; f++) begin
            rnd();
            q.delete();
            send(N, 3, 1'b0, 1'b0);
            compare_frame();
        end

        ramp();
        q.delete();
        send(N, 0, 1'b0, 1'b1);
        compare_frame();
        check("overrun_set", 72'(overrun), 72'(1));
        rnd();
        q.delete();
        send(N, 2, 1'b0, 1'b0);
        compare_frame();
        check("overrun_sticky", 72'(overrun), 72'(1));

        ramp();
        send(8, 0, 1'b0, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        check_zero("midreset");
        reset_n = 1'b1;
        q.delete();
        send(N, 0, 1'b1, 1'b0);
        compare_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
